uart_rx_deserializer: RTL
=========================

Name: uart_rx_deserializer

Overview:
- Asynchronous serial receiver: 8N1 frames in on rxd, parallel bytes out.
- rx_data drives the 8-bit in_port of the rx-data PIO, which Nios software polls.
- Status (data_ready, frame_err, overrun) drives a companion status PIO.
- rx_ack is a one-cycle pulse from a PIO output bit after software reads the byte.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200). Legal range 4..65535.
- CNT_W, 16, bit-period counter width. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rxd  in  1  serial line, asynchronous, idles high
- rx_ack  in  1  one-cycle pulse: byte consumed; clears status flags
- rx_data  out  8  last good received byte
- rx_valid  out  1  one-cycle pulse when rx_data updates
- data_ready  out  1  sticky: unread byte held
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: new byte completed while data_ready=1

Behaviour:
- Reset (async, active-low):
  - 2-FF rxd synchronizer resets to 1.
  - FSM goes to IDLE; counter and bit index go to 0; shift register goes to 0.
  - rx_data=0x00; rx_valid, data_ready, frame_err and overrun all 0.
  - Reset mid-frame abandons the frame with no output update.
- Synchronizer: all logic uses rxs, the second flop. Effective input latency is 2 clk.
- FSM states and transitions:
  - IDLE: rxs==0 -> START, cnt=0.
  - START: cnt counts up. At cnt==CLKS_PER_BIT/2-1 (integer divide), sample rxs.
    - rxs==0 -> DATA, cnt=0, bit index=0.
    - rxs==1 -> IDLE (glitch rejected, no flags).
  - DATA: at cnt==CLKS_PER_BIT-1, sample rxs into shift register LSB first, cnt=0, bit index +1.
    - After the 8th sample -> STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxs.
    - rxs==1 (good frame), on that same edge:
      - rx_data <= shift register; rx_valid=1 for exactly one cycle; data_ready=1.
      - overrun=1 if data_ready was already 1 and rx_ack is not asserted this cycle.
      - Next state IDLE.
    - rxs==0 (framing error):
      - frame_err=1; rx_data, data_ready and rx_valid unchanged.
      - Next state WAIT_HIGH.
  - WAIT_HIGH: stay while rxs==0 (break condition); rxs==1 -> IDLE. No new frame starts until the line returns high.
- rx_ack: clears data_ready, frame_err and overrun on the next edge.
- Simultaneous rx_ack and good-frame completion:
  - data_ready ends 1; overrun not set; frame_err cleared.
  - Completion set wins over ack clear for data_ready.
- Simultaneous rx_ack and stop-bit framing error: frame_err ends 1; data_ready and overrun cleared.
- Back-to-back frames: IDLE is entered half a bit before the stop bit ends, so a start edge directly after the stop bit is caught. No idle gap is required.
- rx_ack is ignored by the FSM; only the status flags react to it.
- Counter never wraps; it is reset at every sample point.

Test Plan (CLKS_PER_BIT=16, bit period 16 clk):
- Frame 0xA5, ideal timing:
  - rx_data=0xA5.
  - rx_valid high exactly 1 cycle, about 9.5 bit periods + 2 clk after the falling edge.
  - data_ready=1 until an rx_ack pulse, then 0 the next cycle.
- rxd low glitch of 5 clk, then high: no rx_valid; FSM back in IDLE; all flags 0.
- Frame 0x3C with stop bit driven 0, then rxd held low for 40 bit periods, then high:
  - frame_err=1; rx_data keeps its prior value; no rx_valid.
  - No further frame is detected until rxd rises.
  - A following 0x5A is received correctly.
- Frames 0x11 then 0x22 back-to-back with no idle gap and no rx_ack: rx_data=0x22, data_ready=1, overrun=1. A single rx_ack clears both flags.
- rx_ack pulsed on the exact stop-sample cycle of frame 0x7E with data_ready=1: rx_data=0x7E, data_ready=1, overrun=0.
- reset_n asserted at bit 4 of frame 0xFF and released mid-frame:
  - All outputs at reset values immediately, with no rx_valid.
  - The receiver resyncs and receives the next clean 0x81.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// 8N1 serial receiver: oversampling FSM turns rxd frames into parallel bytes,
// with sticky status flags (data_ready, frame_err, overrun) cleared by rx_ack.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q, rxs_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             data_ready_q, data_ready_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             half_hit, bit_hit, stop_good, stop_bad;

  assign half_hit = (cnt_q == HALF_LAST);
  assign bit_hit  = (cnt_q == BIT_LAST);

  // Two-flop synchronizer; idles high so reset looks like an idle line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!rxs_q) state_d = S_START;
      S_START:     if (half_hit) state_d = rxs_q ? S_IDLE : S_DATA;
      S_DATA:      if (bit_hit && bit_idx_q == 3'd7) state_d = S_STOP;
      // Leaving STOP at mid-bit lets a start edge right after the stop bit be caught
      S_STOP:      if (bit_hit) state_d = rxs_q ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rxs_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      S_START: begin
        if (half_hit) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_hit) begin
          cnt_d     = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_hit) begin
          cnt_d     = '0;
          stop_good = rxs_q;
          stop_bad  = ~rxs_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
      end
    endcase

    // Completion sets win over the ack clear
    rx_valid_d   = stop_good;
    rx_data_d    = stop_good ? shift_q : rx_data_q;
    data_ready_d = stop_good ? 1'b1 : (rx_ack ? 1'b0 : data_ready_q);
    frame_err_d  = stop_bad  ? 1'b1 : (rx_ack ? 1'b0 : frame_err_q);
    overrun_d    = (stop_good && data_ready_q && !rx_ack) ? 1'b1 :
                   (rx_ack ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      data_ready_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      data_ready_q <= data_ready_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign data_ready = data_ready_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
